// File: rtl/hack_memory_map.sv
// Hack CPU data-memory responder: RAM, screen buffer, keyboard register and screen scan-out.
// Optional sticky illegal-access flag enabled by defining HACK_MMIO_ERR_EN.
module hack_memory_map #(
    parameter int          ROW_WORDS   = 32,
    parameter int          ROWS        = 256,
    parameter logic [14:0] SCREEN_BASE = 15'h4000,
    parameter logic [14:0] KBD_ADDR    = 15'h6000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [14:0] addr_i,
    input  logic [15:0] data_i,
    input  logic        wr_en_i,
    output logic [15:0] data_o,
    input  logic        key_valid_i,
    input  logic [15:0] key_code_i,
    output logic        key_ready_o,
    input  logic        scan_en_i,
    input  logic        pix_ready_i,
    output logic        pix_valid_o,
    output logic [15:0] pix_data_o,
    output logic        pix_sof_o,
    output logic        pix_eol_o,
    output logic        err_o
);

    localparam int          SCREEN_WORDS = ROW_WORDS * ROWS;
    localparam int          PTR_W        = $clog2(SCREEN_WORDS);
    localparam int          RAM_WORDS    = int'(SCREEN_BASE);
    localparam int          RAM_AW       = $clog2(RAM_WORDS);
    localparam logic [14:0] SCREEN_END   = 15'(int'(SCREEN_BASE) + SCREEN_WORDS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SCREEN_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } scan_state_t;

    logic [15:0]      ram    [RAM_WORDS];
    logic [15:0]      screen [SCREEN_WORDS];
    logic [15:0]      kbd_reg;
    logic             in_ram;
    logic             in_screen;
    logic [RAM_AW-1:0] ram_idx;
    logic [PTR_W-1:0] scr_idx;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    scan_state_t      state;

    assign in_ram    = (addr_i < SCREEN_BASE);
    assign in_screen = (addr_i >= SCREEN_BASE) && (addr_i < SCREEN_END);
    assign ram_idx   = RAM_AW'(addr_i);
    assign scr_idx   = PTR_W'(addr_i - SCREEN_BASE);
    assign next_ptr  = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;

    always_comb begin
        data_o = '0;
        if (in_ram) begin
            data_o = ram[ram_idx];
        end else if (in_screen) begin
            data_o = screen[scr_idx];
        end else if (addr_i == KBD_ADDR) begin
            data_o = kbd_reg;
        end
    end

    // Memories are not reset; keyboard address and the unmapped hole drop writes.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && in_ram) begin
            ram[ram_idx] <= data_i;
        end
        if (wr_en_i && in_screen) begin
            screen[scr_idx] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_ready_o <= 1'b0;
            kbd_reg     <= '0;
        end else begin
            key_ready_o <= 1'b1;
            if (key_valid_i && key_ready_o) begin
                kbd_reg <= key_code_i;
            end
        end
    end

    // The FETCH read samples the screen before any same-edge CPU write lands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            ptr         <= '0;
            pix_valid_o <= 1'b0;
            pix_data_o  <= '0;
            pix_sof_o   <= 1'b0;
            pix_eol_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_en_i) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    pix_data_o  <= screen[ptr];
                    pix_valid_o <= 1'b1;
                    pix_sof_o   <= (ptr == '0);
                    pix_eol_o   <= ((32'(ptr) % ROW_WORDS) == (ROW_WORDS - 1));
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (pix_ready_i) begin
                        pix_valid_o <= 1'b0;
                        pix_sof_o   <= 1'b0;
                        pix_eol_o   <= 1'b0;
                        if (scan_en_i) begin
                            ptr   <= next_ptr;
                            state <= FETCH;
                        end else begin
                            ptr   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HACK_MMIO_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if ((wr_en_i && addr_i == KBD_ADDR) || (addr_i > KBD_ADDR)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hack_memory_map.sv
// Directed bench for hack_memory_map: CPU port, keyboard, scan-out scoreboard and error flag.
// Checks the err_o behaviour that matches whether HACK_MMIO_ERR_EN is defined.
module tb_hack_memory_map;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [14:0] addr_i = '0;
    logic [15:0] data_i = '0;
    logic        wr_en_i = 1'b0;
    logic [15:0] data_o;
    logic        key_valid_i = 1'b0;
    logic [15:0] key_code_i = '0;
    logic        key_ready_o;
    logic        scan_en_i = 1'b0;
    logic        pix_ready_i = 1'b0;
    logic        pix_valid_o;
    logic [15:0] pix_data_o;
    logic        pix_sof_o;
    logic        pix_eol_o;
    logic        err_o;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } beat_t;

    beat_t       sb[$];
    logic [15:0] scr_model [8192];
    int          total = 0;
    int          bad = 0;

`ifdef HACK_MMIO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    hack_memory_map dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .wr_en_i     (wr_en_i),
        .data_o      (data_o),
        .key_valid_i (key_valid_i),
        .key_code_i  (key_code_i),
        .key_ready_o (key_ready_o),
        .scan_en_i   (scan_en_i),
        .pix_ready_i (pix_ready_i),
        .pix_valid_o (pix_valid_o),
        .pix_data_o  (pix_data_o),
        .pix_sof_o   (pix_sof_o),
        .pix_eol_o   (pix_eol_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic apply_stimulus(input logic [14:0] addr, input logic [15:0] data, input logic wr);
        addr_i  = addr;
        data_i  = data;
        wr_en_i = wr;
    endtask

    task automatic push_beat(input int idx);
        beat_t b;
        b.data = scr_model[idx];
        b.sof  = (idx == 0);
        b.eol  = ((idx % 32) == 31);
        sb.push_back(b);
    endtask

    // Consumes scoreboard entries on each valid&ready; returns at the negedge before the last handshake edge.
    task automatic run_scan(input int budget);
        int    cycles = 0;
        beat_t exp_b;
        while (sb.size() > 0 && cycles < budget) begin
            if (pix_valid_o && pix_ready_i) begin
                exp_b = sb.pop_front();
                check_output("beat_data", 32'(pix_data_o), 32'(exp_b.data));
                check_output("beat_sof", 32'(pix_sof_o), 32'(exp_b.sof));
                check_output("beat_eol", 32'(pix_eol_o), 32'(exp_b.eol));
                if (sb.size() == 0) break;
            end
            tick();
            cycles++;
        end
        if (sb.size() != 0) begin
            check_output("scan_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [15:0] held_data;

        #2 rst_n_i = 1'b0;
        @(negedge clk_i);
        apply_stimulus(15'h6000, 16'h0000, 1'b0);
        #1;
        check_output("rst_valid", 32'(pix_valid_o), 32'd0);
        check_output("rst_sof", 32'(pix_sof_o), 32'd0);
        check_output("rst_eol", 32'(pix_eol_o), 32'd0);
        check_output("rst_pix_data", 32'(pix_data_o), 32'd0);
        check_output("rst_key_ready", 32'(key_ready_o), 32'd0);
        check_output("rst_err", 32'(err_o), 32'd0);
        check_output("rst_kbd", 32'(data_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        check_output("key_ready_after_rst", 32'(key_ready_o), 32'd1);

        $display("[TB] T1 RAM write/read and hole read");
        apply_stimulus(15'h0010, 16'h1234, 1'b1);
        tick();
        apply_stimulus(15'h0010, 16'h0000, 1'b0);
        #1 check_output("ram_0010", 32'(data_o), 32'h1234);
        apply_stimulus(15'h3FFF, 16'hBEEF, 1'b1);
        tick();
        apply_stimulus(15'h3FFF, 16'h0000, 1'b0);
        #1 check_output("ram_3fff", 32'(data_o), 32'hBEEF);
        check_output("err_before_hole", 32'(err_o), 32'd0);
        apply_stimulus(15'h6005, 16'h0000, 1'b0);
        #1 check_output("hole_6005", 32'(data_o), 32'h0000);
        tick();
        apply_stimulus(15'h0000, 16'h0000, 1'b0);
        check_output("err_after_hole_read", 32'(err_o), 32'(ERR_EN));

        $display("[TB] T2 keyboard capture");
        key_code_i  = 16'h0041;
        key_valid_i = 1'b1;
        tick();
        key_valid_i = 1'b0;
        key_code_i  = 16'h0077;
        apply_stimulus(15'h6000, 16'h0000, 1'b0);
        #1 check_output("kbd_0041", 32'(data_o), 32'h0041);
        apply_stimulus(15'h6000, 16'hFFFF, 1'b1);
        tick();
        apply_stimulus(15'h6000, 16'h0000, 1'b0);
        #1 check_output("kbd_write_ignored", 32'(data_o), 32'h0041);

        $display("[TB] screen fill");
        for (int i = 0; i < 8192; i++) begin
            scr_model[i] = 16'(i * 37) ^ 16'h5A5A;
        end
        scr_model[0]    = 16'hAAAA;
        scr_model[31]   = 16'h5555;
        scr_model[8191] = 16'h1357;
        for (int i = 0; i < 8192; i++) begin
            apply_stimulus(15'(15'h4000 + i), scr_model[i], 1'b1);
            tick();
        end
        apply_stimulus(15'h4000, 16'h0000, 1'b0);
        #1 check_output("scr_4000", 32'(data_o), 32'hAAAA);
        apply_stimulus(15'h5FFF, 16'h0000, 1'b0);
        #1 check_output("scr_5fff", 32'(data_o), 32'h1357);
        apply_stimulus(15'h6000, 16'h0000, 1'b0);

        $display("[TB] T3 full frame plus wrap");
        scan_en_i   = 1'b1;
        pix_ready_i = 1'b1;
        check_output("idle_valid", 32'(pix_valid_o), 32'd0);
        for (int i = 0; i < 8192; i++) push_beat(i);
        push_beat(0);
        tick();
        check_output("fetch_valid", 32'(pix_valid_o), 32'd0);
        tick();
        check_output("present_valid", 32'(pix_valid_o), 32'd1);
        run_scan(20000);
        scan_en_i = 1'b0;
        tick();
        check_output("stop_valid", 32'(pix_valid_o), 32'd0);
        tick();
        check_output("idle_hold_valid", 32'(pix_valid_o), 32'd0);

        $display("[TB] T4 backpressure");
        scan_en_i   = 1'b1;
        pix_ready_i = 1'b0;
        tick();
        tick();
        check_output("bp_valid", 32'(pix_valid_o), 32'd1);
        check_output("bp_data", 32'(pix_data_o), 32'hAAAA);
        check_output("bp_sof", 32'(pix_sof_o), 32'd1);
        check_output("bp_eol", 32'(pix_eol_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("bp_hold_valid", 32'(pix_valid_o), 32'd1);
            check_output("bp_hold_data", 32'(pix_data_o), 32'hAAAA);
            check_output("bp_hold_sof", 32'(pix_sof_o), 32'd1);
            check_output("bp_hold_eol", 32'(pix_eol_o), 32'd0);
        end
        pix_ready_i = 1'b1;
        tick();
        pix_ready_i = 1'b0;
        check_output("bp_after_hs_valid", 32'(pix_valid_o), 32'd0);
        tick();
        check_output("bp_next_valid", 32'(pix_valid_o), 32'd1);
        check_output("bp_next_data", 32'(pix_data_o), 32'(scr_model[1]));
        check_output("bp_next_sof", 32'(pix_sof_o), 32'd0);

        $display("[TB] T5 write collision");
        scan_en_i   = 1'b0;
        pix_ready_i = 1'b1;
        tick();
        scan_en_i   = 1'b1;
        pix_ready_i = 1'b0;
        tick();
        apply_stimulus(15'h4000, 16'h0F0F, 1'b1);
        tick();
        apply_stimulus(15'h4000, 16'h0000, 1'b0);
        scr_model[0] = 16'h0F0F;
        check_output("coll_valid", 32'(pix_valid_o), 32'd1);
        check_output("coll_old_data", 32'(pix_data_o), 32'hAAAA);
        #1 check_output("coll_mem_new", 32'(data_o), 32'h0F0F);
        apply_stimulus(15'h4002, 16'h2222, 1'b1);
        tick();
        apply_stimulus(15'h6000, 16'h0000, 1'b0);
        scr_model[2] = 16'h2222;
        check_output("present_write_data", 32'(pix_data_o), 32'hAAAA);
        scan_en_i   = 1'b0;
        pix_ready_i = 1'b1;
        tick();
        scan_en_i = 1'b1;
        push_beat(0);
        push_beat(1);
        push_beat(2);
        run_scan(50);

        $display("[TB] T6 reset mid-present");
        tick();
        pix_ready_i = 1'b0;
        tick();
        check_output("t6_valid", 32'(pix_valid_o), 32'd1);
        check_output("t6_data", 32'(pix_data_o), 32'(scr_model[3]));
        #2 rst_n_i = 1'b0;
        #1;
        check_output("t6_rst_valid", 32'(pix_valid_o), 32'd0);
        check_output("t6_rst_data", 32'(pix_data_o), 32'd0);
        check_output("t6_rst_key_ready", 32'(key_ready_o), 32'd0);
        check_output("t6_rst_kbd", 32'(data_o), 32'd0);
        check_output("t6_rst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_n_i     = 1'b1;
        pix_ready_i = 1'b1;
        push_beat(0);
        push_beat(1);
        run_scan(50);
        scan_en_i = 1'b0;
        tick();
        check_output("t6_key_ready", 32'(key_ready_o), 32'd1);

        $display("[TB] T7 error flag");
        check_output("t7_err_pre", 32'(err_o), 32'd0);
        apply_stimulus(15'h6001, 16'h1111, 1'b1);
        tick();
        apply_stimulus(15'h0000, 16'h0000, 1'b0);
        check_output("t7_err_set", 32'(err_o), 32'(ERR_EN));
        held_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t7_err_sticky", 32'(err_o), 32'(ERR_EN));
        end
        #1 check_output("t7_ram_0000", 32'(data_o), 32'(held_data));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
